// File: rtl/pomdp_episode_ctrl.sv
// Episode sequencer for the PBVI flow: one solver handshake, then ep_cnt episodes
// of step_cnt simulator steps, each step streamed as a trace record.
module pomdp_episode_ctrl #(
  parameter int N_STATES  = 2,
  parameter int N_ACTIONS = 3,
  parameter int N_OBS     = 2,
  parameter int RW        = 32,
  parameter int ACC_W     = 40,
  parameter int STEP_W    = 16,
  localparam int SW = (N_STATES  > 1) ? $clog2(N_STATES)  : 1,
  localparam int AW = (N_ACTIONS > 1) ? $clog2(N_ACTIONS) : 1,
  localparam int OW = (N_OBS     > 1) ? $clog2(N_OBS)     : 1,
  localparam int TW = AW + OW + SW + 2 * STEP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [STEP_W-1:0] step_cnt,
  input  logic [STEP_W-1:0] ep_cnt,
  output logic              busy,
  output logic              done,
  output logic              solve_start,
  input  logic              solve_done,
  output logic              sim_reseed,
  output logic              sim_req,
  input  logic              sim_ack,
  input  logic [AW-1:0]     sim_action,
  input  logic [OW-1:0]     sim_obs,
  input  logic [SW-1:0]     sim_state,
  input  logic [RW-1:0]     sim_reward,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [TW-1:0]     trace_data,
  output logic [ACC_W-1:0]  total_reward,
  output logic [STEP_W-1:0] ep_done_cnt
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_SOLVE      = 3'd1;
  localparam logic [2:0] S_SOLVE_WAIT = 3'd2;
  localparam logic [2:0] S_EP_START   = 3'd3;
  localparam logic [2:0] S_STEP       = 3'd4;
  localparam logic [2:0] S_TRACE      = 3'd5;
  localparam logic [2:0] S_FINISH     = 3'd6;

  localparam logic [STEP_W-1:0] ONE  = {{(STEP_W-1){1'b0}}, 1'b1};
  localparam logic [STEP_W-1:0] ZERO = {STEP_W{1'b0}};

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [STEP_W-1:0] r_step_cnt;
  logic [STEP_W-1:0] r_ep_cnt;
  logic [STEP_W-1:0] r_step_idx;
  logic [STEP_W-1:0] r_ep_done;
  logic [TW-1:0]     r_trace_data;
  logic [ACC_W-1:0]  r_total;
  logic              w_step_last;
  logic              w_ep_last;

  // Signed add of a sign-extended step reward, clamped to the ACC_W range.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [RW-1:0]    b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W + 1 - RW){b[RW-1]}}, b};
    if (s[ACC_W] != s[ACC_W-1]) begin
      sat_add = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sat_add = s[ACC_W-1:0];
    end
  endfunction

  assign w_step_last = ((r_step_idx + ONE) == r_step_cnt);
  assign w_ep_last   = ((r_ep_done + ONE) == r_ep_cnt);

  // Next-state selection; abort overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:       w_state_nxt = start ? S_SOLVE : S_IDLE;
        S_SOLVE:      w_state_nxt = S_SOLVE_WAIT;
        S_SOLVE_WAIT: w_state_nxt = solve_done ? S_EP_START : S_SOLVE_WAIT;
        S_EP_START: begin
          if (r_step_cnt == ZERO) begin
            w_state_nxt = w_ep_last ? S_FINISH : S_EP_START;
          end else begin
            w_state_nxt = S_STEP;
          end
        end
        S_STEP:       w_state_nxt = sim_ack ? S_TRACE : S_STEP;
        S_TRACE: begin
          if (!trace_ready) begin
            w_state_nxt = S_TRACE;
          end else if (!w_step_last) begin
            w_state_nxt = S_STEP;
          end else begin
            w_state_nxt = w_ep_last ? S_FINISH : S_EP_START;
          end
        end
        S_FINISH:     w_state_nxt = S_IDLE;
        default:      w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State, run configuration, indices, trace record and reward total.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_step_cnt   <= ZERO;
      r_ep_cnt     <= ZERO;
      r_step_idx   <= ZERO;
      r_ep_done    <= ZERO;
      r_trace_data <= {TW{1'b0}};
      r_total      <= {ACC_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (!abort) begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_step_cnt <= step_cnt;
              r_ep_cnt   <= (ep_cnt == ZERO) ? ONE : ep_cnt;
              r_step_idx <= ZERO;
              r_ep_done  <= ZERO;
              r_total    <= {ACC_W{1'b0}};
            end
          end
          S_EP_START: begin
            r_step_idx <= ZERO;
            if (r_step_cnt == ZERO) begin
              r_ep_done <= r_ep_done + ONE;
            end
          end
          S_STEP: begin
            if (sim_ack) begin
              r_trace_data <= {r_ep_done, r_step_idx, sim_action, sim_obs, sim_state};
              r_total      <= sat_add(r_total, sim_reward);
            end
          end
          S_TRACE: begin
            if (trace_ready) begin
              r_step_idx <= r_step_idx + ONE;
              if (w_step_last) begin
                r_ep_done <= r_ep_done + ONE;
              end
            end
          end
          default: begin
            r_step_idx <= r_step_idx;
          end
        endcase
      end
    end
  end

  // Strobes are registered decodes of the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      solve_start <= 1'b0;
      sim_reseed  <= 1'b0;
      sim_req     <= 1'b0;
      trace_valid <= 1'b0;
    end else begin
      busy        <= (w_state_nxt != S_IDLE);
      done        <= (w_state_nxt == S_FINISH);
      solve_start <= (w_state_nxt == S_SOLVE);
      sim_reseed  <= (w_state_nxt == S_EP_START);
      sim_req     <= (w_state_nxt == S_STEP);
      trace_valid <= (w_state_nxt == S_TRACE);
    end
  end

  assign trace_data   = r_trace_data;
  assign total_reward = r_total;
  assign ep_done_cnt  = r_ep_done;

endmodule
